// File: rtl/wash_sequencer_if.sv
// Front-panel request lines and driver/status outputs of the wash sequencer.
interface wash_sequencer_if;
    logic       start;
    logic       door;
    logic       faucet;
    logic       abort;
    logic [1:0] prog;   // the panel's "program" select; that name is an SV keyword
    logic       fill;
    logic       warm;
    logic       wash;
    logic       drain;
    logic       dry;
    logic       f;
    logic [2:0] S;
    logic       paused;
    logic       busy;
    logic       done;

    modport master (
        output start, door, faucet, abort, prog,
        input  fill, warm, wash, drain, dry, f, S, paused, busy, done
    );

    modport slave (
        input  start, door, faucet, abort, prog,
        output fill, warm, wash, drain, dry, f, S, paused, busy, done
    );
endinterface

// File: rtl/wash_sequencer.sv
// Washing-machine phase sequencer: programme-dependent FILL/WARM/WASH/DRAIN/DRY
// walk on a divided timebase, with pause on door/faucet loss and abort-to-drain.
module wash_sequencer #(
    parameter int DIV     = 4,
    parameter int CNT_W   = 8,
    parameter int FILL_T  = 2,
    parameter int WARM_T  = 2,
    parameter int WASH_T  = 3,
    parameter int DRAIN_T = 2,
    parameter int DRY_T   = 2
) (
    input  logic            inpFreq,
    input  logic            rstN,
    wash_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_WARM  = 3'd2,
        ST_WASH  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DRY   = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    localparam int               DIV_W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_T)  - CNT_W'(1);
    localparam logic [CNT_W-1:0] WARM_LAST  = CNT_W'(WARM_T)  - CNT_W'(1);
    localparam logic [CNT_W-1:0] WASH_LAST  = CNT_W'(WASH_T)  - CNT_W'(1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_T) - CNT_W'(1);
    localparam logic [CNT_W-1:0] DRY_LAST   = CNT_W'(DRY_T)   - CNT_W'(1);
    localparam logic [1:0]       P_HOT      = 2'd0;
    localparam logic [1:0]       P_RINSE    = 2'd2;
    localparam logic [1:0]       P_SPIN     = 2'd3;

    state_t           r_state;
    state_t           w_next;
    state_t           w_after;
    state_t           w_first;
    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_tmr;
    logic [CNT_W-1:0] w_last_cnt;
    logic [1:0]       r_prog;
    logic             r_abrt;
    logic             w_abrt_set;
    logic [4:0]       r_drv;
    logic [4:0]       w_drv_next;
    logic             w_busy;
    logic             w_paused;
    logic             w_run;
    logic             w_tick;
    logic             w_end;
    logic             w_chg;

    assign w_busy   = r_state inside {ST_FILL, ST_WARM, ST_WASH, ST_DRAIN, ST_DRY};
    assign w_paused = w_busy & (bus.door | ((r_state == ST_FILL) & ~bus.faucet));
    assign w_run    = w_busy & ~w_paused;
    assign w_tick   = w_run & (r_div == DIV_LAST);
    assign w_end    = w_tick & (r_tmr == w_last_cnt);
    assign w_chg    = (w_next != r_state);
    assign w_first  = (bus.prog == P_SPIN) ? ST_DRAIN : ST_FILL;

    always_comb begin
        w_last_cnt = '0;
        case (r_state)
            ST_FILL:  w_last_cnt = FILL_LAST;
            ST_WARM:  w_last_cnt = WARM_LAST;
            ST_WASH:  w_last_cnt = WASH_LAST;
            ST_DRAIN: w_last_cnt = DRAIN_LAST;
            ST_DRY:   w_last_cnt = DRY_LAST;
            default:  w_last_cnt = '0;
        endcase
    end

    // Successor of the current phase for the latched programme.
    always_comb begin
        w_after = ST_DONE;
        case (r_state)
            ST_FILL:  w_after = (r_prog == P_HOT) ? ST_WARM : ST_WASH;
            ST_WARM:  w_after = ST_WASH;
            ST_WASH:  w_after = ST_DRAIN;
            ST_DRAIN: w_after = (r_abrt || (r_prog == P_RINSE)) ? ST_DONE : ST_DRY;
            default:  w_after = ST_DONE;
        endcase
    end

    always_comb begin
        w_next     = r_state;
        w_abrt_set = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start && !bus.door && bus.faucet) w_next = w_first;
            end
            ST_FILL, ST_WARM, ST_WASH: begin
                // abort wins even when paused or on the phase's last tick
                if (bus.abort) begin
                    w_next     = ST_DRAIN;
                    w_abrt_set = 1'b1;
                end else if (w_end) begin
                    w_next = w_after;
                end
            end
            ST_DRAIN, ST_DRY: begin
                if (w_end) w_next = w_after;
            end
            ST_DONE: begin
                if (!bus.start) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_drv_next = 5'b0;
        case (w_next)
            ST_FILL:  w_drv_next[0] = 1'b1;
            ST_WARM:  w_drv_next[1] = 1'b1;
            ST_WASH:  w_drv_next[2] = 1'b1;
            ST_DRAIN: w_drv_next[3] = 1'b1;
            ST_DRY:   w_drv_next[4] = 1'b1;
            default:  w_drv_next = 5'b0;
        endcase
    end

    always_ff @(posedge inpFreq or negedge rstN) begin
        if (!rstN) begin
            r_state <= ST_IDLE;
            r_div   <= '0;
            r_tmr   <= '0;
            r_prog  <= '0;
            r_abrt  <= 1'b0;
            r_drv   <= '0;
        end else begin
            r_state <= w_next;
            r_drv   <= w_drv_next;
            if ((r_state == ST_IDLE) && w_chg) begin
                r_prog <= bus.prog;
                r_abrt <= 1'b0;
            end else if (w_abrt_set) begin
                r_abrt <= 1'b1;
            end
            if (w_chg) begin
                r_div <= '0;
                r_tmr <= '0;
            end else if (w_tick) begin
                r_div <= '0;
                r_tmr <= r_tmr + CNT_W'(1);
            end else if (w_run) begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    // Registered drives are masked while paused so they drop with the pause input.
    assign bus.fill   = r_drv[0] & ~w_paused;
    assign bus.warm   = r_drv[1] & ~w_paused;
    assign bus.wash   = r_drv[2] & ~w_paused;
    assign bus.drain  = r_drv[3] & ~w_paused;
    assign bus.dry    = r_drv[4] & ~w_paused;
    assign bus.f      = w_tick;
    assign bus.S      = r_state;
    assign bus.paused = w_paused;
    assign bus.busy   = w_busy;
    assign bus.done   = (r_state == ST_DONE);
endmodule

// File: tb/tb_wash_sequencer.sv
// Random-cycle scoreboard bench: each run predicts the phase segments it should
// produce; a negedge monitor measures the segments the sequencer actually emits.
module tb_wash_sequencer;
    localparam int DIV     = 4;
    localparam int FILL_T  = 2;
    localparam int WARM_T  = 2;
    localparam int WASH_T  = 3;
    localparam int DRAIN_T = 2;
    localparam int DRY_T   = 2;

    typedef struct {
        int code;
        int len;
        int drv;
        int pau;
        int fcnt;
    } seg_t;

    logic clk = 1'b0;
    logic rstN;
    int   tests  = 0;
    int   failed = 0;
    bit   mon_en = 1'b0;
    seg_t exp_q[$];

    wash_sequencer_if bus();
    wash_sequencer_if bus2();

    always #5 clk = ~clk;

    wash_sequencer #(
        .DIV(DIV), .CNT_W(8), .FILL_T(FILL_T), .WARM_T(WARM_T),
        .WASH_T(WASH_T), .DRAIN_T(DRAIN_T), .DRY_T(DRY_T)
    ) dut (
        .inpFreq(clk),
        .rstN   (rstN),
        .bus    (bus)
    );

    wash_sequencer #(
        .DIV(1), .CNT_W(8), .FILL_T(FILL_T), .WARM_T(WARM_T),
        .WASH_T(1), .DRAIN_T(DRAIN_T), .DRY_T(DRY_T)
    ) dut2 (
        .inpFreq(clk),
        .rstN   (rstN),
        .bus    (bus2)
    );

    task automatic chk(input bit ok, input string nm, input int act, input int want);
        tests++;
        if (!ok) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, want, $time);
        end
    endtask

    function automatic int ticks(input int code);
        case (code)
            1:       return FILL_T;
            2:       return WARM_T;
            3:       return WASH_T;
            4:       return DRAIN_T;
            5:       return DRY_T;
            default: return 0;
        endcase
    endfunction

    task automatic push_seg(input int c, input int len, input int drv, input int pau, input int fc);
        seg_t s;
        s = '{c, len, drv, pau, fc};
        exp_q.push_back(s);
    endtask

    // Inputs change just after the edge; the programme select is scrambled every
    // clock so only the value at the start edge may matter.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.prog = 2'($urandom);
    endtask

    task automatic wait_phase(input int code, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (int'(bus.S) == code) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk(ok, "wait_phase", int'(bus.S), code);
    endtask

    // ---------------- monitor ----------------
    int m_code = 0, m_len = 0, m_pau = 0, m_f = 0, m_busy = 0, m_done = 0;
    int m_drv[5];

    task automatic close_seg();
        seg_t e;
        int   dsum;
        bit   dok;
        if (exp_q.size() == 0) begin
            chk(1'b0, "seg_unexpected", m_code, -1);
            return;
        end
        e    = exp_q.pop_front();
        dsum = 0;
        dok  = 1'b1;
        for (int l = 0; l < 5; l++) begin
            dsum += m_drv[l];
            if (m_drv[l] != ((l + 1 == e.code) ? e.drv : 0)) dok = 1'b0;
        end
        chk(m_code == e.code, "seg_phase", m_code, e.code);
        chk(m_len == e.len, "seg_clocks", m_len, e.len);
        chk(dok, "seg_drive_clocks", dsum, e.drv);
        chk(m_pau == e.pau, "seg_paused_clocks", m_pau, e.pau);
        chk(m_f == e.fcnt, "seg_ticks", m_f, e.fcnt);
        chk(m_busy == ((e.code <= 5) ? e.len : 0), "seg_busy", m_busy, (e.code <= 5) ? e.len : 0);
        chk(m_done == ((e.code == 6) ? e.len : 0), "seg_done", m_done, (e.code == 6) ? e.len : 0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (int'(bus.S) != m_code) begin
                if (m_code != 0) close_seg();
                m_code = int'(bus.S);
                m_len = 0; m_pau = 0; m_f = 0; m_busy = 0; m_done = 0;
                for (int l = 0; l < 5; l++) m_drv[l] = 0;
            end
            if (m_code != 0) begin
                m_len++;
                m_pau    += int'(bus.paused);
                m_f      += int'(bus.f);
                m_busy   += int'(bus.busy);
                m_done   += int'(bus.done);
                m_drv[0] += int'(bus.fill);
                m_drv[1] += int'(bus.warm);
                m_drv[2] += int'(bus.wash);
                m_drv[3] += int'(bus.drain);
                m_drv[4] += int'(bus.dry);
            end
        end
    end

    // ---------------- one randomized cycle ----------------
    // kind: 0 clean, 1 door pause, 2 faucet drop, 3 abort pulse, 4 abort while paused
    task automatic run_cycle(input int p, input int kind_in);
        int ph[5];
        int nph, qi, code, dd, k, j, n, h, kind, c, full, pau;
        bit ok;
        kind = kind_in;
        case (p)
            0:       begin ph = '{1, 2, 3, 4, 5}; nph = 5; end
            1:       begin ph = '{1, 3, 4, 5, 0}; nph = 4; end
            2:       begin ph = '{1, 3, 4, 0, 0}; nph = 3; end
            default: begin ph = '{4, 5, 0, 0, 0}; nph = 2; end
        endcase
        qi   = $urandom_range(nph - 1, 0);
        code = ph[qi];
        dd   = ticks(code) * DIV;
        if (kind == 4 && code > 3) kind = 1;
        k = $urandom_range(dd, 1);
        j = $urandom_range(dd - 1, 0);
        n = $urandom_range(10, 1);
        h = $urandom_range(3, 0);
        if (kind == 2 && code != 1) begin
            j = 0;
            n = $urandom_range(dd - 1, 1);
        end

        for (int i = 0; i < nph; i++) begin
            c    = ph[i];
            full = ticks(c) * DIV;
            if (i == qi && c <= 3 && (kind == 3 || kind == 4)) begin
                if (kind == 3) push_seg(c, k, k, 0, k / DIV);
                else           push_seg(c, j + 1, j, 1, j / DIV);
                push_seg(4, DRAIN_T * DIV, DRAIN_T * DIV, 0, DRAIN_T);
                break;
            end
            pau = (i == qi && (kind == 1 || (kind == 2 && c == 1))) ? n : 0;
            push_seg(c, full + pau, full, pau, ticks(c));
        end
        push_seg(6, h + 1, 0, 0, 0);

        bus.start = 1'b1;
        bus.prog  = 2'(p);
        tick();
        if (kind != 0) begin
            wait_phase(code, ok);
            if (ok) begin
                case (kind)
                    1, 2: begin
                        repeat (j) tick();
                        if (kind == 1) bus.door = 1'b1;
                        else           bus.faucet = 1'b0;
                        repeat (n) tick();
                        bus.door   = 1'b0;
                        bus.faucet = 1'b1;
                    end
                    3: begin
                        repeat (k - 1) tick();
                        bus.abort = 1'b1;
                        tick();
                        bus.abort = 1'b0;
                    end
                    default: begin
                        repeat (j) tick();
                        bus.door  = 1'b1;
                        bus.abort = 1'b1;
                        tick();
                        bus.door  = 1'b0;
                        bus.abort = 1'b0;
                    end
                endcase
            end
        end
        wait_phase(6, ok);
        repeat (h) tick();
        bus.start = 1'b0;
        tick();
        repeat ($urandom_range(3, 1)) tick();
    endtask

    initial begin
        bit ok;
        int cb, cw, cf;
        if (FILL_T < 1 || WARM_T < 1 || WASH_T < 1 || DRAIN_T < 1 || DRY_T < 1)
            $fatal(1, "FAIL param_check: a phase duration is zero");

        rstN = 1'b0;
        bus.start  = 1'b0; bus.door  = 1'b0; bus.faucet  = 1'b1; bus.abort  = 1'b0; bus.prog  = 2'd0;
        bus2.start = 1'b0; bus2.door = 1'b0; bus2.faucet = 1'b1; bus2.abort = 1'b0; bus2.prog = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        chk(bus.S == 3'd0, "reset_phase", int'(bus.S), 0);
        chk({bus.fill, bus.warm, bus.wash, bus.drain, bus.dry, bus.f, bus.paused, bus.busy, bus.done} == 9'b0,
            "reset_outputs",
            int'({bus.fill, bus.warm, bus.wash, bus.drain, bus.dry, bus.f, bus.paused, bus.busy, bus.done}), 0);
        rstN = 1'b1;
        tick();

        // start is refused while the door is open or water is absent
        bus.start = 1'b1;
        bus.door  = 1'b1;
        repeat (4) tick();
        chk(bus.S == 3'd0, "gate_door_open", int'(bus.S), 0);
        bus.door   = 1'b0;
        bus.faucet = 1'b0;
        repeat (4) tick();
        chk(bus.S == 3'd0, "gate_no_faucet", int'(bus.S), 0);
        chk({bus.f, bus.busy, bus.paused, bus.done} == 4'b0, "idle_status",
            int'({bus.f, bus.busy, bus.paused, bus.done}), 0);
        bus.start  = 1'b0;
        bus.faucet = 1'b1;
        tick();

        mon_en = 1'b1;
        for (int r = 0; r < 28; r++)
            run_cycle((r < 4) ? r : $urandom_range(3, 0), (r < 4) ? 0 : $urandom_range(4, 0));
        tick();
        mon_en = 1'b0;
        chk(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);

        // asynchronous reset in the middle of DRAIN
        bus.start = 1'b1;
        bus.prog  = 2'd0;
        tick();
        wait_phase(4, ok);
        tick();
        tick();
        chk(bus.drain == 1'b1, "pre_reset_drain", int'(bus.drain), 1);
        #2;
        rstN = 1'b0;
        #1;
        chk(bus.S == 3'd0, "async_reset_phase", int'(bus.S), 0);
        chk({bus.fill, bus.warm, bus.wash, bus.drain, bus.dry, bus.f, bus.busy, bus.done} == 8'b0,
            "async_reset_outputs",
            int'({bus.fill, bus.warm, bus.wash, bus.drain, bus.dry, bus.f, bus.busy, bus.done}), 0);
        bus.start = 1'b0;
        tick();
        rstN = 1'b1;
        tick();
        chk(bus.S == 3'd0, "post_reset_idle", int'(bus.S), 0);

        // DIV=1, WASH_T=1 instance: hot cycle is 2+2+1+2+2 clocks, tick every clock
        bus2.start = 1'b1;
        bus2.prog  = 2'd0;
        tick();
        cb = 0; cw = 0; cf = 0;
        for (int c = 0; c < 100 && bus2.S != 3'd6; c++) begin
            cb += int'(bus2.busy);
            cw += int'(bus2.wash);
            cf += int'(bus2.f);
            tick();
        end
        chk(bus2.S == 3'd6, "div1_reaches_done", int'(bus2.S), 6);
        chk(cw == 1, "div1_wash_clocks", cw, 1);
        chk(cf == 9, "div1_tick_count", cf, 9);
        chk(cb == 9, "div1_busy_clocks", cb, 9);
        bus2.start = 1'b0;
        tick();
        chk(bus2.S == 3'd0, "div1_back_to_idle", int'(bus2.S), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
